// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and a debug loader, with locked debug bursts.
// Optional round-robin contention policy: define DMEM_ARB_RR_EN.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StCpu, StDbg, StDbgLock} state_e;

    localparam logic [3:0] MaxCnt = 4'(MAX_BURST);

    state_e     state_q, state_d;
    logic       last_dbg_q, last_dbg_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       lock_hold;

    // Debug keeps the memory while its locked burst is live and below the limit.
    assign lock_hold = (state_q == StDbgLock) && dbg_req && dbg_lock && (burst_cnt_q < MaxCnt);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_dbg_q  <= 1'b1;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = StIdle;
        last_dbg_d  = last_dbg_q;
        burst_cnt_d = 4'd0;
        if (cpu_gnt) begin
            state_d    = StCpu;
            last_dbg_d = 1'b0;
        end else if (dbg_gnt) begin
            last_dbg_d = 1'b1;
            if (dbg_lock) begin
                state_d = StDbgLock;
                // Saturate so a broken lock stays broken until the CPU gets a slot.
                burst_cnt_d = (burst_cnt_q >= MaxCnt) ? MaxCnt : burst_cnt_q + 4'd1;
            end else begin
                state_d = StDbg;
            end
        end
    end

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst) begin
            if (lock_hold) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
                cpu_gnt = last_dbg_q;
                dbg_gnt = ~last_dbg_q;
`else
                cpu_gnt = 1'b1;
`endif
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
            if (dbg_gnt && !dbg_we) dbg_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: bench-side memory, read-data scoreboard queues,
// immediate assertions at every comparison point.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already applied just after a rising edge; check mid-cycle, then after the edge.
    task automatic step(input string tag, input bit eg_c, input bit eg_d);
        logic [7:0]  ea;
        logic [31:0] ew;
        logic        ewe, rv_c, rv_d;
        #4;
        ea  = eg_c ? cpu_addr : (eg_d ? dbg_addr : 8'h00);
        ew  = eg_c ? cpu_wdata : (eg_d ? dbg_wdata : 32'h0);
        ewe = (eg_c & cpu_we) | (eg_d & dbg_we);
        chk($sformatf("%s cpu_gnt", tag), 32'(cpu_gnt), 32'(eg_c));
        chk($sformatf("%s dbg_gnt", tag), 32'(dbg_gnt), 32'(eg_d));
        chk($sformatf("%s cpu_stall", tag), 32'(cpu_stall), 32'(cpu_req & ~eg_c));
        chk($sformatf("%s mem_we", tag), 32'(mem_we), 32'(ewe));
        chk($sformatf("%s mem_addr", tag), 32'(mem_addr), 32'(ea));
        chk($sformatf("%s mem_wdata", tag), mem_wdata, ew);
        rv_c = eg_c & ~cpu_we;
        rv_d = eg_d & ~dbg_we;
        if (rv_c) cpu_q.push_back(mem[cpu_addr]);
        if (rv_d) dbg_q.push_back(mem[dbg_addr]);
        @(posedge clk);
        #1;
        chk($sformatf("%s cpu_rvalid", tag), 32'(cpu_rvalid), 32'(rv_c));
        chk($sformatf("%s dbg_rvalid", tag), 32'(dbg_rvalid), 32'(rv_d));
        if (rv_c) chk($sformatf("%s cpu_rdata", tag), cpu_rdata, cpu_q.pop_front());
        if (rv_d) chk($sformatf("%s dbg_rdata", tag), dbg_rdata, dbg_q.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
        mem[5] = 32'h1234_5678;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 32'hFFFF_FFFF;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b0; dbg_addr = 8'h34; dbg_wdata = 32'h0;

        // Reset: no grants, no writes, stall follows cpu_req
        step("reset", 1'b0, 1'b0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset dbg_rdata", dbg_rdata, 32'h0);
        chk("reset no write", mem[8'h33], 32'hA5A5_0033);

        // CPU read alone, zero wait
        rst = 1'b0; dbg_req = 1'b0;
        cpu_we = 1'b0; cpu_addr = 8'h05;
        step("cpu_rd05", 1'b1, 1'b0);
        chk("cpu_rd05 data", cpu_rdata, 32'h1234_5678);
        cpu_req = 1'b0;
        step("idle", 1'b0, 1'b0);
        chk("rdata hold", cpu_rdata, 32'h1234_5678);

        // Debug write then CPU read-back
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'hDEAD_BEEF;
        step("dbg_wr20", 1'b0, 1'b1);
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        step("cpu_rd20", 1'b1, 1'b0);
        chk("cpu_rd20 data", cpu_rdata, 32'hDEAD_BEEF);

        // Debug read alone
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h05;
        step("dbg_rd05", 1'b0, 1'b1);

        // Locked burst: 4 debug grants, CPU slot, debug resumes at 0x14
        dbg_we = 1'b1; dbg_lock = 1'b1;
        dbg_addr = 8'h10; dbg_wdata = 32'hB000_0010;
        step("burst 10", 1'b0, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        for (int i = 1; i < 4; i++) begin
            dbg_addr = 8'(8'h10 + i); dbg_wdata = 32'hB000_0010 + 32'(i);
            step($sformatf("burst %0h", 8'h10 + i), 1'b0, 1'b1);
        end
        dbg_addr = 8'h14; dbg_wdata = 32'hB000_0014;
        step("burst break", 1'b1, 1'b0);
        cpu_req = 1'b0;
        for (int i = 4; i < 8; i++) begin
            dbg_addr = 8'(8'h10 + i); dbg_wdata = 32'hB000_0010 + 32'(i);
            step($sformatf("burst %0h", 8'h10 + i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("burst mem %0h", 8'h10 + i), mem[8'h10 + i], 32'hB000_0010 + 32'(i));

        // Lock dropped mid-burst: CPU wins the same cycle
        dbg_req = 1'b0;
        step("idle2", 1'b0, 1'b0);
        dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h08;
        step("lock start", 1'b0, 1'b1);
        cpu_req = 1'b1; cpu_addr = 8'h09; dbg_lock = 1'b0;
        step("lock drop", 1'b1, 1'b0);

        // Contention from reset
        cpu_req = 1'b0; dbg_req = 1'b0; rst = 1'b1;
        step("rst2", 1'b0, 1'b0);
        rst = 1'b0; cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
        cpu_addr = 8'h05; dbg_addr = 8'h06;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            step($sformatf("contend %0d", i), (i % 2) == 0, (i % 2) == 1);
`else
            step($sformatf("contend %0d", i), 1'b1, 1'b0);
`endif
        end

        // Reset right after a CPU read grant
        dbg_req = 1'b0; cpu_addr = 8'h07;
        step("pre-rst rd", 1'b1, 1'b0);
        rst = 1'b1; dbg_req = 1'b1;
        step("rst3", 1'b0, 1'b0);
        chk("rst3 cpu_rdata", cpu_rdata, 32'h0);
        chk("rst3 dbg_rdata", dbg_rdata, 32'h0);
        rst = 1'b0;
        step("post-rst contest", 1'b1, 1'b0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        step("final idle", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
